shevm_pwr_seq_ctrl: RTL and testbench
=====================================

Name: shevm_pwr_seq_ctrl

Overview:
- Power-good sequencer and controller for the board-side protect/enable pins: NAND_WP, NOR_WP#, EEPROM_WP, PCA9306_EN and the DSP TIMI0 gate.
- Filters VCC3_AUX_PGOOD, then releases the four pins in a fixed order with programmable spacing.
- Software can force an orderly re-lock through a req/ack handshake.
- Sits between the pad ring (pins driven directly from its outputs) and the FPGA register block.

Parameters:
- DEB_CYC, 48000, consecutive cycles pgood must be high before sequencing starts (1 ms at 48 MHz).
- STEP_CYC, 4800, cycles between successive pin transitions (100 us).
- NSTEP, 4, number of sequenced pins (fixed order, not for override).

Ports:
- main_48mhz_clk_r_i  in  1  48 MHz system clock.
- rst_i  in  1  synchronous reset, active-high.
- pgood_i  in  1  raw VCC3_AUX_PGOOD, already 2-flop synchronised upstream.
- lock_req_i  in  1  software request to re-protect all pins (level).
- timi0_src_i  in  1  timer source for DSP TIMI0.
- pca9306_en_o  out  1  I2C level-shifter enable.
- eeprom_wp_o  out  1  EEPROM WP pin.
- nor_wp_n_o  out  1  NOR WP# pin.
- nand_wp_o  out  1  NAND WP pin.
- dsp_timi0_o  out  1  gated TIMI0.
- lock_ack_o  out  1  all pins in safe state due to lock_req_i.
- seq_state_o  out  3  state encoding for status register.
- pgood_fault_o  out  1  sticky: pgood dropped after reaching ON; cleared only by rst_i.

Behaviour:
- Clock and reset: one clock (main_48mhz_clk_r_i); reset rst_i is synchronous, active-high.
- Outputs are registered. On reset every output is 0 and the state is OFF.
- Safe state: all four pins 0 and dsp_timi0_o = 0.
- Release order (step index 0..3): pca9306_en_o, eeprom_wp_o, nor_wp_n_o, nand_wp_o. Each transitions 0 -> 1.
- Re-lock order is the reverse (3..0).
- States (seq_state_o): OFF=0, DEB=1, UP=2, ON=3, DOWN=4, LOCKED=5.
- OFF:
  - pgood_i=1 -> DEB with deb_cnt cleared.
- DEB:
  - deb_cnt increments while pgood_i=1; any pgood_i=0 -> OFF.
  - When deb_cnt reaches DEB_CYC-1 and pgood_i=1 -> UP with step=0 and step_cnt=0.
- UP:
  - On entry, pin[step] goes high on the next edge.
  - Then wait STEP_CYC cycles; step increments.
  - After pin[3] is set and STEP_CYC elapses -> ON.
  - Edge n of pin release occurs exactly n*STEP_CYC cycles after entering UP.
- ON:
  - dsp_timi0_o = timi0_src_i, registered, 1-cycle latency.
  - Elsewhere dsp_timi0_o = 0.
- DOWN:
  - Entered from ON or UP when lock_req_i=1.
  - Clears the highest set pin immediately, then one further pin per STEP_CYC, down to pin 0.
  - After pin 0 clears -> LOCKED.
  - A lock_req_i arriving mid-UP aborts UP; no further pin is set.
- LOCKED:
  - lock_ack_o=1.
  - lock_req_i=0 -> UP from step 0 (no re-debounce); lock_ack_o falls on the same edge.
  - lock_req_i deassert during DOWN is ignored until LOCKED is reached.
- pgood loss:
  - pgood_i=0 in any state other than OFF/DEB -> OFF next edge, all outputs 0 at once (no ordering), lock_ack_o=0.
  - If the state was ON, DOWN or LOCKED, pgood_fault_o is set.
  - This has priority over lock_req_i.
- Simultaneous pgood rise and lock_req_i=1 in OFF: DEB completes, then the controller goes directly to LOCKED without releasing any pin.
- Counters:
  - deb_cnt is $clog2(DEB_CYC) bits; step_cnt is $clog2(STEP_CYC) bits.
  - Counters saturate and never wrap.
  - Both counters clear on every state change.

Decomposition:
- Shared package shevm_pwr_pkg holds: the state encodings (OFF..LOCKED) and the pin index constants (PCA=0, EEP=1, NOR=2, NAND=3).
- One sub-module, shevm_pgood_deb, holds the debounce counter and outputs pgood_stable. It is reusable for the other rails.
- The FSM and step counter stay in the top module.

Test Plan (DEB_CYC=8, STEP_CYC=4):
- Reset held 3 cycles with pgood_i=1 -> all outputs 0 and seq_state_o=0 throughout. After release, DEB lasts 8 cycles, then pins rise at UP+0, +4, +8, +12, and ON is reached at UP+16.
- pgood_i pulses high for 5 cycles, then low -> returns to OFF; no pin ever rises; pgood_fault_o=0.
- In ON, assert lock_req_i -> nand_wp_o falls next edge, then nor_wp_n_o at +4, eeprom_wp_o at +8, pca9306_en_o at +12. lock_ack_o=1 at +16. Deassert lock_req_i -> re-release begins the next cycle.
- lock_req_i asserted 1 cycle after eeprom_wp_o rises in UP -> nor_wp_n_o and nand_wp_o never rise; eeprom_wp_o falls next edge; pca9306_en_o falls 4 cycles later; LOCKED follows.
- pgood_i drops in ON while timi0_src_i toggles -> next edge all pins 0, dsp_timi0_o=0, pgood_fault_o=1 and stays 1 after pgood returns and ON is re-reached.
- In ON, timi0_src_i toggles 1010 -> dsp_timi0_o reproduces 1010 delayed by one cycle.

Source files
------------

// File: rtl/shevm_pwr_pkg.sv
// shevm_pwr_pkg: shared state encodings and pin indices for the power sequencer
package shevm_pwr_pkg;

   localparam int NSTEP = 4;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_DEB    = 3'd1,
      ST_UP     = 3'd2,
      ST_ON     = 3'd3,
      ST_DOWN   = 3'd4,
      ST_LOCKED = 3'd5
   } seq_state_t;

   localparam logic [1:0] PIN_PCA  = 2'd0;
   localparam logic [1:0] PIN_EEP  = 2'd1;
   localparam logic [1:0] PIN_NOR  = 2'd2;
   localparam logic [1:0] PIN_NAND = 2'd3;

endpackage

// File: rtl/shevm_pgood_deb.sv
// shevm_pgood_deb: counts consecutive high cycles of a rail power-good while enabled
module shevm_pgood_deb #(
   parameter int DEB_CYC = 48000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_pgood,
   output logic o_stable
);

   localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

   logic [DW-1:0] r_cnt;

   // any low sample or disable restarts the count; saturate at DEB_LAST
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en || !i_pgood) r_cnt <= '0;
      else if (r_cnt != DEB_LAST) r_cnt <= r_cnt + DW'(1);
   end

   assign o_stable = i_en && i_pgood && (r_cnt == DEB_LAST);

endmodule

// File: rtl/shevm_pwr_seq_ctrl.sv
// shevm_pwr_seq_ctrl: pgood-qualified ordered release and re-lock of board protect/enable pins
module shevm_pwr_seq_ctrl
   import shevm_pwr_pkg::*;
#(
   parameter int DEB_CYC  = 48000,
   parameter int STEP_CYC = 4800
) (
   input  logic       main_48mhz_clk_r_i,
   input  logic       rst_i,
   input  logic       pgood_i,
   input  logic       lock_req_i,
   input  logic       timi0_src_i,
   output logic       pca9306_en_o,
   output logic       eeprom_wp_o,
   output logic       nor_wp_n_o,
   output logic       nand_wp_o,
   output logic       dsp_timi0_o,
   output logic       lock_ack_o,
   output logic [2:0] seq_state_o,
   output logic       pgood_fault_o
);

   localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

   seq_state_t       r_state, w_state_nxt;
   logic [1:0]       r_step, w_step_nxt;
   logic [SW-1:0]    r_cnt, w_cnt_nxt;
   logic [NSTEP-1:0] r_pins, w_pins_nxt;
   logic             r_timi0, r_ack, r_fault;
   logic             w_pgood_stable, w_step_done, w_fault_set;
   logic [1:0]       w_hi;

   shevm_pgood_deb #(.DEB_CYC(DEB_CYC)) u_deb (
      .i_clk   (main_48mhz_clk_r_i),
      .i_rst   (rst_i),
      .i_en    (r_state == ST_DEB),
      .i_pgood (pgood_i),
      .o_stable(w_pgood_stable)
   );

   assign w_step_done = (r_cnt == STEP_LAST);
   assign w_hi        = (r_state == ST_ON) ? PIN_NAND : r_step;
   assign w_fault_set = !pgood_i && (r_state inside {ST_ON, ST_DOWN, ST_LOCKED});

   // next state, step index and pin image; pgood loss overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_pins_nxt  = r_pins;
      w_cnt_nxt   = ((r_state inside {ST_UP, ST_DOWN}) && !w_step_done) ? r_cnt + SW'(1) : '0;
      case (r_state)
         ST_OFF: if (pgood_i) w_state_nxt = ST_DEB;
         ST_DEB: begin
            if (!pgood_i) w_state_nxt = ST_OFF;
            else if (w_pgood_stable) begin
               w_state_nxt         = lock_req_i ? ST_LOCKED : ST_UP;
               w_step_nxt          = PIN_PCA;
               w_pins_nxt[PIN_PCA] = !lock_req_i;
            end
         end
         ST_UP, ST_ON: begin
            if (lock_req_i) begin
               w_state_nxt      = ST_DOWN;
               w_step_nxt       = w_hi;
               w_pins_nxt[w_hi] = 1'b0;
            end else if (r_state == ST_UP && w_step_done) begin
               if (r_step == PIN_NAND) w_state_nxt = ST_ON;
               else begin
                  w_step_nxt                  = r_step + 2'd1;
                  w_pins_nxt[r_step + 2'd1]   = 1'b1;
               end
            end
         end
         ST_DOWN: begin
            if (w_step_done) begin
               if (r_step == PIN_PCA) w_state_nxt = ST_LOCKED;
               else begin
                  w_step_nxt                  = r_step - 2'd1;
                  w_pins_nxt[r_step - 2'd1]   = 1'b0;
               end
            end
         end
         ST_LOCKED: begin
            if (!lock_req_i) begin
               w_state_nxt         = ST_UP;
               w_step_nxt          = PIN_PCA;
               w_pins_nxt[PIN_PCA] = 1'b1;
            end
         end
         default: w_state_nxt = ST_OFF;
      endcase
      if (!pgood_i && r_state != ST_OFF) begin
         w_state_nxt = ST_OFF;
         w_step_nxt  = PIN_PCA;
         w_pins_nxt  = '0;
      end
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end

   // state and output registers; TIMI0 passes only while the next state is ON
   always_ff @(posedge main_48mhz_clk_r_i) begin
      if (rst_i) begin
         r_state <= ST_OFF;
         r_step  <= PIN_PCA;
         r_cnt   <= '0;
         r_pins  <= '0;
         r_timi0 <= 1'b0;
         r_ack   <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pins  <= w_pins_nxt;
         r_timi0 <= (w_state_nxt == ST_ON) && timi0_src_i;
         r_ack   <= (w_state_nxt == ST_LOCKED);
         r_fault <= r_fault || w_fault_set;
      end
   end

   assign pca9306_en_o  = r_pins[PIN_PCA];
   assign eeprom_wp_o   = r_pins[PIN_EEP];
   assign nor_wp_n_o    = r_pins[PIN_NOR];
   assign nand_wp_o     = r_pins[PIN_NAND];
   assign dsp_timi0_o   = r_timi0;
   assign lock_ack_o    = r_ack;
   assign seq_state_o   = r_state;
   assign pgood_fault_o = r_fault;

endmodule

// File: tb/tb_shevm_pwr_seq_ctrl.sv
// tb_shevm_pwr_seq_ctrl: directed stimulus with a cycle-stamped expected-event scoreboard
module tb_shevm_pwr_seq_ctrl;

   typedef struct {
      int         cyc;
      logic [9:0] v;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_i, pgood_i, lock_req_i, timi0_src_i;
   logic       pca9306_en_o, eeprom_wp_o, nor_wp_n_o, nand_wp_o;
   logic       dsp_timi0_o, lock_ack_o, pgood_fault_o;
   logic [2:0] seq_state_o;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic       done = 1'b0;
   logic       flushed = 1'b0;
   logic [9:0] prev = '0;
   ev_t        sb[$];

   shevm_pwr_seq_ctrl #(.DEB_CYC(8), .STEP_CYC(4)) dut (
      .main_48mhz_clk_r_i(clk),
      .rst_i             (rst_i),
      .pgood_i           (pgood_i),
      .lock_req_i        (lock_req_i),
      .timi0_src_i       (timi0_src_i),
      .pca9306_en_o      (pca9306_en_o),
      .eeprom_wp_o       (eeprom_wp_o),
      .nor_wp_n_o        (nor_wp_n_o),
      .nand_wp_o         (nand_wp_o),
      .dsp_timi0_o       (dsp_timi0_o),
      .lock_ack_o        (lock_ack_o),
      .seq_state_o       (seq_state_o),
      .pgood_fault_o     (pgood_fault_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // expected output after edge c: {fault, ack, timi0, pins{nand,nor,eep,pca}, state}
   task automatic ev(input int c, input logic [2:0] st, input logic [3:0] p,
                     input logic t, input logic a, input logic f);
      ev_t e;
      e.cyc = c;
      e.v   = {f, a, t, p, st};
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: any output change must match a scheduled event; scheduled events are checked on their cycle
   always @(negedge clk) begin
      logic [9:0] cur;
      ev_t        e;
      cur = {pgood_fault_o, lock_ack_o, dsp_timi0_o, nand_wp_o, nor_wp_n_o,
             eeprom_wp_o, pca9306_en_o, seq_state_o};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_event cyc=%0d expected=%b", e.cyc, e.v);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if (cur !== e.v) begin
            errors++;
            $display("FAIL event cyc=%0d got=%b expected=%b", cyc, cur, e.v);
         end
      end else if (cur !== prev) begin
         checks++;
         errors++;
         $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, prev);
      end
      prev = cur;
      if (done && !flushed) begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL never_seen cyc=%0d expected=%b", e.cyc, e.v);
         end
         flushed = 1'b1;
      end
   end

   initial begin
      rst_i = 1'b1; pgood_i = 1'b1; lock_req_i = 1'b0; timi0_src_i = 1'b0;
      // reset held with pgood high, then debounce and full release
      ev(1, 3'd0, 4'b0000, 0, 0, 0);
      ev(2, 3'd0, 4'b0000, 0, 0, 0);
      ev(3, 3'd0, 4'b0000, 0, 0, 0);
      ev(4, 3'd1, 4'b0000, 0, 0, 0);
      ev(12, 3'd2, 4'b0001, 0, 0, 0);
      ev(16, 3'd2, 4'b0011, 0, 0, 0);
      ev(20, 3'd2, 4'b0111, 0, 0, 0);
      ev(24, 3'd2, 4'b1111, 0, 0, 0);
      ev(28, 3'd3, 4'b1111, 0, 0, 0);
      wait_cyc(3);
      rst_i = 1'b0;
      // TIMI0 pass-through 1010 with one cycle latency
      ev(31, 3'd3, 4'b1111, 1, 0, 0);
      ev(32, 3'd3, 4'b1111, 0, 0, 0);
      ev(33, 3'd3, 4'b1111, 1, 0, 0);
      ev(34, 3'd3, 4'b1111, 0, 0, 0);
      wait_cyc(30); timi0_src_i = 1'b1;
      wait_cyc(31); timi0_src_i = 1'b0;
      wait_cyc(32); timi0_src_i = 1'b1;
      wait_cyc(33); timi0_src_i = 1'b0;
      // lock from ON: reverse order, ack, then re-release
      ev(37, 3'd4, 4'b0111, 0, 0, 0);
      ev(41, 3'd4, 4'b0011, 0, 0, 0);
      ev(45, 3'd4, 4'b0001, 0, 0, 0);
      ev(49, 3'd4, 4'b0000, 0, 0, 0);
      ev(53, 3'd5, 4'b0000, 0, 1, 0);
      ev(56, 3'd2, 4'b0001, 0, 0, 0);
      ev(60, 3'd2, 4'b0011, 0, 0, 0);
      wait_cyc(36); lock_req_i = 1'b1;
      wait_cyc(55); lock_req_i = 1'b0;
      // lock one cycle after eeprom release aborts UP
      ev(62, 3'd4, 4'b0001, 0, 0, 0);
      ev(66, 3'd4, 4'b0000, 0, 0, 0);
      ev(70, 3'd5, 4'b0000, 0, 1, 0);
      ev(73, 3'd2, 4'b0001, 0, 0, 0);
      ev(77, 3'd2, 4'b0011, 0, 0, 0);
      ev(81, 3'd2, 4'b0111, 0, 0, 0);
      ev(85, 3'd2, 4'b1111, 0, 0, 0);
      ev(89, 3'd3, 4'b1111, 0, 0, 0);
      wait_cyc(61); lock_req_i = 1'b1;
      wait_cyc(72); lock_req_i = 1'b0;
      // pgood loss in ON: immediate safe state, sticky fault survives re-release
      ev(91, 3'd3, 4'b1111, 1, 0, 0);
      ev(92, 3'd0, 4'b0000, 0, 0, 1);
      ev(95, 3'd1, 4'b0000, 0, 0, 1);
      ev(103, 3'd2, 4'b0001, 0, 0, 1);
      ev(107, 3'd2, 4'b0011, 0, 0, 1);
      ev(111, 3'd2, 4'b0111, 0, 0, 1);
      ev(115, 3'd2, 4'b1111, 0, 0, 1);
      ev(119, 3'd3, 4'b1111, 0, 0, 1);
      wait_cyc(90); timi0_src_i = 1'b1;
      wait_cyc(91); timi0_src_i = 1'b0; pgood_i = 1'b0;
      wait_cyc(92); timi0_src_i = 1'b1;
      wait_cyc(93); timi0_src_i = 1'b0;
      wait_cyc(94); pgood_i = 1'b1;
      // second reset clears the fault
      ev(122, 3'd0, 4'b0000, 0, 0, 0);
      ev(123, 3'd0, 4'b0000, 0, 0, 0);
      wait_cyc(121); rst_i = 1'b1; pgood_i = 1'b0;
      wait_cyc(123); rst_i = 1'b0;
      // five-cycle pgood glitch never leaves debounce
      ev(126, 3'd1, 4'b0000, 0, 0, 0);
      ev(131, 3'd0, 4'b0000, 0, 0, 0);
      wait_cyc(125); pgood_i = 1'b1;
      wait_cyc(130); pgood_i = 1'b0;
      // pgood and lock together: straight to LOCKED, then pgood loss sets fault
      ev(134, 3'd1, 4'b0000, 0, 0, 0);
      ev(142, 3'd5, 4'b0000, 0, 1, 0);
      ev(146, 3'd0, 4'b0000, 0, 0, 1);
      wait_cyc(133); pgood_i = 1'b1; lock_req_i = 1'b1;
      wait_cyc(145); pgood_i = 1'b0;
      wait_cyc(152);
      done = 1'b1;
      wait_cyc(156);
      if (!flushed) begin
         errors++;
         $display("FAIL monitor_flush flushed=%b expected=1", flushed);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
